// File: rtl/axi4_lite_regfile_v3.sv
// AXI4-Lite slave register file: byte-strobed writes, independent AW/W slots,
// read-only registers mapped to status inputs, SLVERR on bad accesses.
module axi4_lite_regfile_v3 #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int REGISTERS    = 16,
  parameter logic [REGISTERS-1:0] RO_MASK = '0,
  localparam int BYTES = DATA_SIZE / 8,
  localparam int OFS   = $clog2(BYTES),
  localparam int IDX_W = (REGISTERS > 1) ? $clog2(REGISTERS) : 1
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDRESS_SIZE-1:0]        s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_SIZE-1:0]           s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  input  logic [ADDRESS_SIZE-1:0]        s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_SIZE-1:0]           s_axi_wdata,
  input  logic [BYTES-1:0]               s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  output logic [REGISTERS*DATA_SIZE-1:0] reg_o,
  input  logic [REGISTERS*DATA_SIZE-1:0] status_i,
  output logic                           wr_pulse_o,
  output logic [IDX_W-1:0]               wr_index_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_SIZE-1:0] regs [REGISTERS];

  logic                 aw_full;
  logic                 aw_err;
  logic [IDX_W-1:0]     aw_idx;
  logic                 w_full;
  logic [DATA_SIZE-1:0] w_data;
  logic [BYTES-1:0]     w_strb;

  logic [IDX_W-1:0] awaddr_idx;
  logic [IDX_W-1:0] araddr_idx;
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < REGISTERS;
  endfunction

  // A transfer happens on a rising edge where valid && ready are both high.
  // Every ready is a pure function of local registers, so no valid/ready
  // input ever reaches a ready output combinationally.
  assign s_axi_awready = !aw_full;
  assign s_axi_wready  = !w_full;
  assign s_axi_arready = !s_axi_rvalid;

  assign awaddr_idx = s_axi_awaddr[OFS +: IDX_W];
  assign araddr_idx = s_axi_araddr[OFS +: IDX_W];
  assign aw_hs      = s_axi_awvalid && !aw_full;
  assign w_hs       = s_axi_wvalid && !w_full;
  assign ar_hs      = s_axi_arvalid && !s_axi_rvalid;
  assign commit     = aw_full && w_full && (!s_axi_bvalid || s_axi_bready);

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < REGISTERS; i++) regs[i] <= '0;
      aw_full      <= 1'b0;
      aw_err       <= 1'b0;
      aw_idx       <= '0;
      w_full       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
      wr_pulse_o   <= 1'b0;
      wr_index_o   <= '0;
    end else begin
      wr_pulse_o <= 1'b0;

      // Error status is resolved at AW acceptance so commit only checks a flag.
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= awaddr_idx;
        aw_err  <= !in_range(awaddr_idx) || RO_MASK[awaddr_idx];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end

      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= aw_err ? RESP_SLVERR : RESP_OKAY;
        if (!aw_err) begin
          for (int b = 0; b < BYTES; b++) begin
            if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
          end
          wr_pulse_o <= 1'b1;
          wr_index_o <= aw_idx;
        end
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      // Reads sample regs before any same-edge commit lands: old value wins.
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        if (!in_range(araddr_idx)) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= RESP_SLVERR;
        end else if (RO_MASK[araddr_idx]) begin
          s_axi_rdata <= status_i[int'(araddr_idx)*DATA_SIZE +: DATA_SIZE];
          s_axi_rresp <= RESP_OKAY;
        end else begin
          s_axi_rdata <= regs[araddr_idx];
          s_axi_rresp <= RESP_OKAY;
        end
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < REGISTERS; g++) begin : g_reg_o
    assign reg_o[g*DATA_SIZE +: DATA_SIZE] = regs[g];
  end

  // Address bits outside the decoded index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr, s_axi_awaddr};

endmodule

// File: tb/tb_axi4_lite_regfile_v3.sv
// Scoreboard bench for axi4_lite_regfile_v3: randomized AXI4-Lite traffic
// against an array-based register model, plus directed corner cases.
module tb_axi4_lite_regfile_v3;
  localparam int DW   = 32;
  localparam int NREG = 12;
  localparam logic [NREG-1:0] RO = 12'h220;

  logic              aclk;
  logic              areset;
  logic [31:0]       s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DW-1:0]     s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [31:0]       s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DW-1:0]     s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [NREG*DW-1:0] reg_o;
  logic [NREG*DW-1:0] status_i;
  logic              wr_pulse_o;
  logic [3:0]        wr_index_o;

  axi4_lite_regfile_v3 #(
    .ADDRESS_SIZE(32), .DATA_SIZE(DW), .REGISTERS(NREG), .RO_MASK(RO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .reg_o(reg_o), .status_i(status_i), .wr_pulse_o(wr_pulse_o), .wr_index_o(wr_index_o)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  logic [33:0] rd_exp_q [$];
  logic [1:0]  b_exp_q [$];
  logic [3:0]  pulse_exp_q [$];
  logic [31:0] m_regs [NREG];
  logic [31:0] m_status [NREG];
  int n_vec = 0;
  int n_err = 0;
  bit rand_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic int idx_of(input logic [31:0] addr);
    return (addr / 4) % 16;
  endfunction

  function automatic bit bad_write(input int idx);
    if (idx >= NREG) return 1'b1;
    return RO[idx];
  endfunction

  task automatic set_status();
    for (int i = 0; i < NREG; i++) begin
      m_status[i] = $urandom;
      status_i[i*DW +: DW] = m_status[i];
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge aclk) begin
    if (!areset) begin
      if (s_axi_rvalid && s_axi_rready) begin
        if (rd_exp_q.size() == 0) timeout_fail("r_unexpected_response");
        else check("read_resp_data", {s_axi_rresp, s_axi_rdata}, rd_exp_q.pop_front());
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_exp_q.size() == 0) timeout_fail("b_unexpected_response");
        else check("bresp", s_axi_bresp, b_exp_q.pop_front());
      end
      if (wr_pulse_o) begin
        if (pulse_exp_q.size() == 0) timeout_fail("wr_pulse_unexpected");
        else check("wr_index", wr_index_o, pulse_exp_q.pop_front());
      end
    end
  end

  always @(posedge aclk) begin
    if (rand_bp) begin
      #1;
      s_axi_bready = ($urandom_range(0, 3) != 0);
      s_axi_rready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
    int idx;
    int cyc;
    bit aw_done, w_done, aw_take, w_take;
    idx = idx_of(addr);
    if (bad_write(idx)) begin
      b_exp_q.push_back(2'b10);
    end else begin
      b_exp_q.push_back(2'b00);
      pulse_exp_q.push_back(4'(idx));
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
    end
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done && (cyc >= w_dly);
      @(negedge aclk);
      if (w_done && !aw_done) check("wready_low_after_w", s_axi_wready, 1'b0);
      if (aw_done && !w_done) check("awready_low_after_aw", s_axi_awready, 1'b0);
      aw_take = s_axi_awvalid && s_axi_awready;
      w_take  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk);
      #1;
      aw_done = aw_done || aw_take;
      w_done  = w_done || w_take;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) timeout_fail("write_handshake");
  endtask

  task automatic issue_read_exp(input logic [31:0] addr, input logic [33:0] exp);
    int cyc;
    bit taken;
    rd_exp_q.push_back(exp);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    taken = 1'b0;
    cyc   = 0;
    while (!taken && cyc < 100) begin
      @(negedge aclk);
      taken = s_axi_arready;
      @(posedge aclk);
      #1;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    if (!taken) timeout_fail("read_handshake");
  endtask

  task automatic issue_read(input logic [31:0] addr);
    int idx;
    idx = idx_of(addr);
    if (idx >= NREG)  issue_read_exp(addr, {2'b10, 32'h0});
    else if (RO[idx]) issue_read_exp(addr, {2'b00, m_status[idx]});
    else              issue_read_exp(addr, {2'b00, m_regs[idx]});
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((rd_exp_q.size() + b_exp_q.size() + pulse_exp_q.size()) != 0 && cyc < 500) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
    if ((rd_exp_q.size() + b_exp_q.size() + pulse_exp_q.size()) != 0) begin
      timeout_fail("drain_responses");
      rd_exp_q.delete();
      b_exp_q.delete();
      pulse_exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] old_val;
  logic [31:0] a;

  initial begin
    areset = 1'b1;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    set_status();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    @(negedge aclk);
    check("rst_awready", s_axi_awready, 1'b1);
    check("rst_wready", s_axi_wready, 1'b1);
    check("rst_arready", s_axi_arready, 1'b1);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rdata_rresp", {s_axi_rresp, s_axi_rdata}, 34'h0);
    check("rst_bresp", s_axi_bresp, 2'b00);
    check("rst_pulse_index", {wr_pulse_o, wr_index_o}, 5'h0);
    check("rst_reg_o", reg_o[63:0], 64'h0);
    @(posedge aclk); #1;

    // Full write, AW and W together, with latency checks.
    issue_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0);
    @(negedge aclk);
    check("wr_lat_bvalid_n1", s_axi_bvalid, 1'b0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("wr_lat_bvalid_n2", s_axi_bvalid, 1'b1);
    check("wr_lat_pulse_n2", {wr_pulse_o, wr_index_o}, {1'b1, 4'd1});
    check("wr_lat_reg1", reg_o[63:32], 32'hDEADBEEF);
    @(posedge aclk); #1;
    drain();
    issue_read(32'h4);
    drain();

    // Partial strobe.
    issue_write(32'h8, 32'h11223344, 4'hF, 0, 0);
    drain();
    issue_write(32'h8, 32'hAABBCCDD, 4'b0101, 0, 0);
    drain();
    check("strobe_reg2", reg_o[2*DW +: DW], 32'h11BB33DD);

    // W three cycles before AW.
    issue_write(32'hC, 32'h5A5A5A5A, 4'hF, 3, 0);
    drain();
    check("decoupled_reg3", reg_o[3*DW +: DW], 32'h5A5A5A5A);

    // Error cases and read-only mapping.
    issue_read(32'h30);
    issue_read(32'h40);
    issue_write(32'h14, 32'h01020304, 4'hF, 0, 0);
    issue_write(32'h38, 32'h0F0F0F0F, 4'hF, 1, 0);
    drain();
    check("ro_reg5_unchanged", reg_o[5*DW +: DW], 32'h0);
    issue_read(32'h14);
    drain();

    // Write backpressure: second pair sits in the slots.
    s_axi_bready = 1'b0;
    old_val = m_regs[7];
    issue_write(32'h18, 32'h0BAD0001, 4'hF, 0, 0);
    issue_write(32'h1C, 32'h0BAD0002, 4'hF, 0, 0);
    repeat (3) begin
      @(negedge aclk);
      check("bp_awready", s_axi_awready, 1'b0);
      check("bp_wready", s_axi_wready, 1'b0);
      check("bp_bvalid", s_axi_bvalid, 1'b1);
      check("bp_reg7_held", reg_o[7*DW +: DW], old_val);
      @(posedge aclk); #1;
    end
    s_axi_bready = 1'b1;
    drain();
    check("bp_reg7_final", reg_o[7*DW +: DW], 32'h0BAD0002);

    // Read backpressure.
    s_axi_rready = 1'b0;
    issue_read(32'h4);
    repeat (3) begin
      @(negedge aclk);
      check("rbp_rvalid", s_axi_rvalid, 1'b1);
      check("rbp_arready", s_axi_arready, 1'b0);
      check("rbp_rdata", s_axi_rdata, 32'hDEADBEEF);
      @(posedge aclk); #1;
    end
    s_axi_rready = 1'b1;
    drain();

    // Read handshake on the commit edge returns the old value.
    old_val = m_regs[3];
    issue_write(32'hC, 32'h12345678, 4'hF, 0, 0);
    issue_read_exp(32'hC, {2'b00, old_val});
    drain();
    issue_read(32'hC);
    drain();

    // Reset with a B response pending.
    s_axi_bready = 1'b0;
    issue_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("rst_pending_bvalid", s_axi_bvalid, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    b_exp_q.delete();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    s_axi_bready = 1'b1;
    @(negedge aclk);
    check("midrst_bvalid", s_axi_bvalid, 1'b0);
    check("midrst_reg_o", reg_o, '0);
    check("midrst_awready", s_axi_awready, 1'b1);
    @(posedge aclk); #1;

    // Randomized traffic with random B/R backpressure.
    set_status();
    rand_bp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = ($urandom & 32'hFFFF_FFC3) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 2) != 0)
        issue_write(a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
      else
        issue_read(a);
      drain();
    end
    rand_bp = 1'b0;
    @(posedge aclk); #1;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    drain();

    for (int i = 0; i < NREG; i++) check("final_reg_o", reg_o[i*DW +: DW], m_regs[i]);
    check("queues_empty", rd_exp_q.size() + b_exp_q.size() + pulse_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
